// File: rtl/result_serializer.sv
// Buffers packed multi-lane accelerator sums in a circular FIFO and streams them out
// one lane word at a time over a valid/ready handshake, lowest lane first.
module result_serializer #(
    parameter int unsigned BIT_LENGTH = 8,
    parameter int unsigned PORT_COUNT = 3,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic [2*PORT_COUNT*BIT_LENGTH-1:0] sumIn,
    input  logic                               sumValid,
    output logic [2*BIT_LENGTH-1:0]            dataOut,
    output logic                               dataValid,
    input  logic                               dataReady,
    output logic                               lastWord,
    input  logic                               clrOverflow,
    output logic                               overflow,
    output logic                               FULL,
    output logic                               EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]         count
);

    localparam int unsigned WW = 2 * BIT_LENGTH;
    localparam int unsigned SW = WW * PORT_COUNT;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [LW-1:0] LastLane = LW'(PORT_COUNT - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [SW-1:0]   mem_q [DEPTH];

    logic pop, push, drop, hs;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        lane_d   = lane_q;
        valid_d  = valid_q;
        last_d   = last_q;
        pop      = 1'b0;
        hs       = valid_q && dataReady;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    lane_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (PORT_COUNT == 1);
                    state_d = StSend;
                end
            end
            StSend: begin
                if (hs) begin
                    if (lane_q != LastLane) begin
                        lane_d  = lane_q + LW'(1);
                        shreg_d = shreg_q >> WW;
                        last_d  = (lane_d == LastLane);
                    end else if (count_q != '0) begin
                        // Reload straight from the FIFO so back-to-back results have no bubble.
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        lane_d  = '0;
                        last_d  = (PORT_COUNT == 1);
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        shreg_d = '0;
                        lane_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        push = sumValid && ((count_q != DepthC) || pop);
        drop = sumValid && !push;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DepthC);
        empty_d = (count_d == '0);

        ovf_d = ovf_q;
        if (clrOverflow) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            shreg_q  <= '0;
            lane_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            shreg_q  <= shreg_d;
            lane_q   <= lane_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= sumIn;
    end

    // Shift register is cleared on leaving SEND, so its low lane reads 0 when idle.
    assign dataOut   = shreg_q[WW-1:0];
    assign dataValid = valid_q;
    assign lastWord  = last_q;
    assign overflow  = ovf_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign count     = count_q;

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter BIT_LENGTH, default 8, operand width; each result word is 2*BIT_LENGTH bits.
REQ-002 Parameter PORT_COUNT, default 3, number of adder lanes packed in one accelerator result.
REQ-003 Parameter DEPTH, default 4, result-buffer entries; power of two, >= 2.
REQ-004 Clk  input  1  single clock; all state on rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 sumIn  input  2*PORT_COUNT*BIT_LENGTH  flat accelerator sum; lane i = bits [(i+1)*2*BIT_LENGTH-1 : i*2*BIT_LENGTH].
REQ-007 sumValid  input  1  accelerator ready; one-cycle pulse per result.
REQ-008 dataOut  output  2*BIT_LENGTH  current serialized lane word.
REQ-009 dataValid  output  1  dataOut holds a valid word.
REQ-010 dataReady  input  1  consumer accepts word when high with dataValid.
REQ-011 lastWord  output  1  high with dataValid on lane PORT_COUNT-1.
REQ-012 clrOverflow  input  1  synchronous clear of overflow.
REQ-013 overflow  output  1  sticky, result dropped.
REQ-014 FULL  output  1  buffer holds DEPTH entries.
REQ-015 EMPTY  output  1  buffer holds 0 entries.
REQ-016 count  output  $clog2(DEPTH+1)  buffer occupancy.

Function
REQ-017 Buffer is a DEPTH-entry circular FIFO of full-width sums with registered write/read pointers wrapping modulo DEPTH.
REQ-018 Push occurs at an edge where sumValid=1 and (count<DEPTH or a pop occurs at the same edge).
REQ-019 sumValid=1 with count=DEPTH and no pop at the same edge drops the result, leaves buffer unchanged, and sets overflow at that edge.
REQ-020 overflow clears only on Rst or clrOverflow=1; simultaneous set and clear leaves overflow=1.
REQ-021 Simultaneous push and pop leaves count unchanged; FULL/EMPTY/count are registered and reflect the state after each edge.
REQ-022 FSM states IDLE and SEND; reset state IDLE.
REQ-023 IDLE: if count>0, pop head into shift register, laneIdx=0, go SEND; dataValid=1 from that edge.
REQ-024 Latency: sumValid sampled at edge k into empty buffer with FSM IDLE -> dataValid=1, dataOut=lane 0 after edge k+1.
REQ-025 SEND: dataOut=lane laneIdx of held entry; lastWord=1 iff laneIdx=PORT_COUNT-1.
REQ-026 dataOut, lastWord, dataValid hold stable while dataValid=1 and dataReady=0.
REQ-027 Handshake (dataValid & dataReady) at laneIdx<PORT_COUNT-1 increments laneIdx.
REQ-028 Handshake at laneIdx=PORT_COUNT-1: if count>0 pop next entry, laneIdx=0, stay SEND (no bubble); else dataValid=0, go IDLE.
REQ-029 Lanes emitted lowest index first; words unmodified (no saturation, no sign change).
REQ-030 dataOut is 0 whenever dataValid=0.

Reset
REQ-031 Rst=1 asynchronously forces: state IDLE, pointers 0, count=0, EMPTY=1, FULL=0, dataValid=0, lastWord=0, dataOut=0, overflow=0, laneIdx=0.
REQ-032 Reset mid-SEND discards the held entry and all buffered entries; no partial word appears after release.
REQ-033 First push is accepted at the first rising edge after Rst deasserts.

Verification (BIT_LENGTH=8, PORT_COUNT=3, DEPTH=4)
REQ-034 Single result: sumIn=0x0003_0002_0001, sumValid 1 cycle, dataReady=1 -> 0x0001,0x0002,0x0003 on 3 consecutive cycles starting 2 edges after push, lastWord with 0x0003 only, then EMPTY=1, dataValid=0.
REQ-035 Backpressure: as REQ-034 with dataReady=0 for 5 cycles on lane 1 -> dataOut=0x0002 held stable, no word lost or repeated.
REQ-036 Overflow: 5 pushes (values 1..5 in lane 0) with dataReady=0 and FSM having popped entry 1 -> FULL=1 after 5th push, 6th push drops, overflow=1; drain yields entries 1..5 in order, 15 words total; clrOverflow clears overflow.
REQ-037 Back-to-back: two results pushed on consecutive cycles, dataReady=1 -> 6 words on 6 consecutive cycles, lastWord on cycles 3 and 6.
REQ-038 Full simultaneous: count=4, sumValid=1 at the same edge as a last-lane handshake -> push accepted, count stays 4, overflow stays 0.
REQ-039 Reset mid-send: Rst pulsed during lane 1 -> all outputs at reset values immediately, EMPTY=1; subsequent single push reproduces REQ-034 exactly.
